// File: rtl/fsm_flow_ctrl_param_pkg.sv
// rtl/fsm_flow_ctrl_param_pkg.sv - shared state encoding and level-width helper for TLP flow control
package fsm_flow_ctrl_param_pkg;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    localparam int MAX_CH = 16;

    // A level counter must hold 0..DEPTH inclusive, hence depth+1 codes.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic is_flowing(input state_t s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

endpackage

// File: rtl/fsm_flow_ctrl_param_ch_flow.sv
// rtl/fsm_flow_ctrl_param_ch_flow.sv - per-channel pause hysteresis and continue pulse
module fsm_flow_ctrl_param_ch_flow #(
    parameter int LVL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LVL_W-1:0] level,
    input  logic [LVL_W-1:0] alto,
    input  logic [LVL_W-1:0] bajo,
    input  logic             enable,
    input  logic             force_on,
    input  logic             clear,
    input  logic             pulse_en,
    output logic             pause,
    output logic             cont
);

    logic pause_q;
    logic pause_nx;
    logic cont_q;

    // Clear beats force beats hysteresis; between the watermarks the flag holds.
    always_comb begin
        pause_nx = pause_q;
        if (clear) begin
            pause_nx = 1'b0;
        end else if (force_on) begin
            pause_nx = 1'b1;
        end else if (enable) begin
            if (level >= alto) begin
                pause_nx = 1'b1;
            end else if (level <= bajo) begin
                pause_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pause_q <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            pause_q <= pause_nx;
            cont_q  <= pulse_en & pause_q & ~pause_nx;
        end
    end

    assign pause = pause_q;
    assign cont  = cont_q;

endmodule

// File: rtl/fsm_flow_ctrl_param.sv
// rtl/fsm_flow_ctrl_param.sv - NUM_CH-channel flow-control FSM between FIFO bank and TLP arbiter
module fsm_flow_ctrl_param
    import fsm_flow_ctrl_param_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DEPTH  = 8,
    localparam int LVL_W  = lvl_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [LVL_W-1:0]        umbral_alto,
    input  logic [LVL_W-1:0]        umbral_bajo,
    input  logic [NUM_CH*LVL_W-1:0] fifo_level,
    input  logic [NUM_CH-1:0]       fifo_empty,
    input  logic [NUM_CH-1:0]       fifo_full,
    input  logic [NUM_CH-1:0]       fifo_error,
    output logic [NUM_CH-1:0]       error_full,
    output logic [NUM_CH-1:0]       pause,
    output logic [NUM_CH-1:0]       continue_pulse,
    output logic                    idle,
    output logic [4:0]              state
);

    state_t             state_q;
    state_t             state_nx;
    logic [LVL_W-1:0]   alto_q;
    logic [LVL_W-1:0]   bajo_q;
    logic [NUM_CH-1:0]  ef_q;
    logic [NUM_CH-1:0]  ef_nx;
    logic [NUM_CH-1:0]  hit;
    logic [NUM_CH-1:0]  force_on;
    logic               idle_q;
    logic               all_empty;
    logic               cfg_bad;
    logic               flowing;
    logic               next_flowing;

    assign hit          = fifo_error | fifo_full;
    assign all_empty    = &fifo_empty;
    assign cfg_bad      = bajo_q >= alto_q;
    assign flowing      = is_flowing(state_q);
    assign next_flowing = is_flowing(state_nx);

    always_comb begin
        state_nx = state_q;
        if (init) begin
            state_nx = ST_INIT;
        end else begin
            case (state_q)
                ST_RESET:  state_nx = ST_INIT;
                ST_INIT: begin
                    if (cfg_bad)        state_nx = ST_ERROR;
                    else if (all_empty) state_nx = ST_IDLE;
                    else                state_nx = ST_ACTIVE;
                end
                ST_IDLE: begin
                    if (|hit)           state_nx = ST_ERROR;
                    else if (!all_empty) state_nx = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (|hit)           state_nx = ST_ERROR;
                    else if (all_empty) state_nx = ST_IDLE;
                end
                ST_ERROR:  state_nx = ST_ERROR;
                default:   state_nx = ST_RESET;
            endcase
        end
    end

    // A bad watermark pair flags every channel so the arbiter stalls them all.
    always_comb begin
        ef_nx = ef_q;
        if (init) begin
            ef_nx = '0;
        end else if (state_q == ST_INIT && cfg_bad) begin
            ef_nx = '1;
        end else if (flowing || state_q == ST_ERROR) begin
            ef_nx = ef_q | hit;
        end
    end

    // Forcing uses the upcoming flags so pause lands with error_full, not a cycle later.
    assign force_on = (state_nx == ST_ERROR) ? ef_nx : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            alto_q  <= '0;
            bajo_q  <= '0;
            ef_q    <= '0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            ef_q    <= ef_nx;
            idle_q  <= (state_q == ST_IDLE) && all_empty;
            if (init) begin
                alto_q <= umbral_alto;
                bajo_q <= umbral_bajo;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fsm_flow_ctrl_param_ch_flow #(
            .LVL_W(LVL_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .level    (fifo_level[i*LVL_W +: LVL_W]),
            .alto     (alto_q),
            .bajo     (bajo_q),
            .enable   (flowing),
            .force_on (force_on[i]),
            .clear    (init),
            .pulse_en (next_flowing),
            .pause    (pause[i]),
            .cont     (continue_pulse[i])
        );
    end

    assign state      = state_q;
    assign error_full = ef_q;
    assign idle       = idle_q;

endmodule
